// File: rtl/coproc_pkg.sv
// Shared definitions for the matrix coprocessor: default geometry,
// instruction opcodes and the memory-access state encoding.
package coproc_pkg;

    localparam int DATA_W  = 8;
    localparam int N       = 5;
    localparam int NUM_MAT = 3;

    typedef enum logic [3:0] {
        OP_READ      = 4'b0001,
        OP_WRITE     = 4'b0010,
        OP_ADD       = 4'b0011,
        OP_SUB       = 4'b0100,
        OP_MUL       = 4'b0101,
        OP_SCALE     = 4'b0110,
        OP_TRANSPOSE = 4'b0111,
        OP_DET2      = 4'b1000,
        OP_DET3      = 4'b1001,
        OP_DET4      = 4'b1010,
        OP_CLEAR     = 4'b1011,
        OP_DET5      = 4'b1100
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_RELEASE
    } state_t;

endpackage

// File: rtl/matrix_addr_gen.sv
// Combinational (matrix, row, col) to linear RAM address translation with
// range check. Shared with the arithmetic units.
module matrix_addr_gen
    import coproc_pkg::*;
#(
    parameter int N_DIM   = coproc_pkg::N,
    parameter int MATS    = coproc_pkg::NUM_MAT,
    parameter int ADDR_W  = $clog2(MATS * N_DIM * N_DIM)
) (
    input  logic [1:0]        matrix_sel,
    input  logic [2:0]        row,
    input  logic [2:0]        col,
    output logic [ADDR_W-1:0] addr,
    output logic              valid
);

    localparam logic [ADDR_W-1:0] MAT_STRIDE = ADDR_W'(N_DIM * N_DIM);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(N_DIM);

    // Row-major layout, matrices stacked back to back.
    always_comb begin
        addr  = ADDR_W'(matrix_sel) * MAT_STRIDE
              + ADDR_W'(row) * ROW_STRIDE
              + ADDR_W'(col);
        valid = (int'(row) < N_DIM) && (int'(col) < N_DIM)
              && (int'(matrix_sel) < MATS);
    end

endmodule

// File: rtl/matrix_mem_access.sv
// Executes READ/WRITE instructions against the external shared matrix RAM:
// address translation, one-cycle write strobe, read-latency wait, done/error.
module matrix_mem_access
    import coproc_pkg::*;
#(
    parameter int DATA_W   = coproc_pkg::DATA_W,
    parameter int N        = coproc_pkg::N,
    parameter int NUM_MAT  = coproc_pkg::NUM_MAT,
    parameter int ADDR_W   = $clog2(NUM_MAT * N * N),
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              wr,
    input  logic [1:0]        matrix_sel,
    input  logic [2:0]        row,
    input  logic [2:0]        col,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              error,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    state_t            state;
    logic              req_wr;
    logic              req_valid;
    logic [CNT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0] lin_addr;
    logic              addr_ok;

    matrix_addr_gen #(
        .N_DIM  (N),
        .MATS   (NUM_MAT),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .matrix_sel (matrix_sel),
        .row        (row),
        .col        (col),
        .addr       (lin_addr),
        .valid      (addr_ok)
    );

    // Request sequencer; every output is a register updated here.
    // The address and write strobe are registered at the acceptance edge so
    // they are presented to the RAM during the ISSUE cycle; the range flag is
    // captured alongside so ISSUE only needs the latched result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            req_wr    <= 1'b0;
            req_valid <= 1'b0;
            lat_cnt   <= '0;
            rdata     <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            busy      <= 1'b0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
        end else begin
            done   <= 1'b0;
            ram_we <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        req_wr    <= wr;
                        req_valid <= addr_ok;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                        if (addr_ok) begin
                            ram_addr <= lin_addr;
                            if (wr) begin
                                ram_we    <= 1'b1;
                                ram_wdata <= wdata;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (!req_valid) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (req_wr) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        lat_cnt <= CNT_W'(READ_LAT - 1);
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt == '0) begin
                        rdata <= ram_rdata;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!start) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mem_access.sv
// Self-checking bench for matrix_mem_access: RAM model, transaction-level
// reference model, per-cycle compare process, directed and random requests.
module tb_matrix_mem_access;

    localparam int DW       = 8;
    localparam int AW       = 7;
    localparam int RD_LAT   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          wr;
    logic [1:0]    matrix_sel;
    logic [2:0]    row;
    logic [2:0]    col;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          done;
    logic          error;
    logic          busy;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    matrix_mem_access #(
        .DATA_W   (DW),
        .N        (5),
        .NUM_MAT  (3),
        .ADDR_W   (AW),
        .READ_LAT (RD_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .wr         (wr),
        .matrix_sel (matrix_sel),
        .row        (row),
        .col        (col),
        .wdata      (wdata),
        .rdata      (rdata),
        .done       (done),
        .error      (error),
        .busy       (busy),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // External RAM: address sampled on an edge, data on the output after
    // the following edge (two-edge read latency).
    logic [DW-1:0] mem [0:127];
    logic [AW-1:0] addr_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        addr_q    <= ram_addr;
        ram_rdata <= mem[addr_q];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [DW-1:0] shadow [0:127];
    bit            m_active = 1'b0;
    int            m_e      = 0;     // edges since acceptance, acceptance = 1
    int            m_lat    = 0;     // edge count at which done is high
    bit            m_valid, m_wr;
    int            m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] exp_rdata = '0;
    bit            exp_err   = 1'b0;
    bit            m_post_rst = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            m_post_rst = reset;
            if (reset) begin
                m_active  = 1'b0;
                m_e       = 0;
                exp_rdata = '0;
                exp_err   = 1'b0;
            end else if (m_active) begin
                m_e++;
                if (m_e == m_lat) begin
                    if (!m_valid)  exp_err   = 1'b1;
                    else if (!m_wr) exp_rdata = shadow[m_addr];
                end
                if (m_e >= m_lat + 2 && !start) m_active = 1'b0;
            end else if (start) begin
                m_valid = (row < 5) && (col < 5) && (matrix_sel < 3);
                m_wr    = wr;
                m_addr  = int'(matrix_sel) * 25 + int'(row) * 5 + int'(col);
                m_wdata = wdata;
                m_lat   = (!m_valid || m_wr) ? 2 : 2 + RD_LAT;
                m_active = 1'b1;
                m_e      = 1;
                exp_err  = 1'b0;
                if (m_valid && m_wr) shadow[m_addr] = m_wdata;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("done",  done,  m_active && m_e == m_lat);
                chk("busy",  busy,  m_active);
                chk("ram_we", ram_we, m_active && m_e == 1 && m_valid && m_wr);
                chk("rdata", rdata, exp_rdata);
                chk("error", error, exp_err);
                if (m_active && m_e == 1 && m_valid) begin
                    chk("ram_addr", ram_addr, m_addr);
                    if (m_wr) chk("ram_wdata", ram_wdata, m_wdata);
                end
                if (m_post_rst) begin
                    chk("rst_ram_addr", ram_addr, 0);
                    chk("rst_ram_wdata", ram_wdata, 0);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input logic [1:0] s, input logic [2:0] r, input logic [2:0] c,
                          input logic w, input logic [DW-1:0] d, input int hold,
                          output int lat_seen, output logic [AW-1:0] addr_seen,
                          output int n_done);
        int k;
        k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("idle_before_req", busy, 0);
        matrix_sel = s; row = r; col = c; wr = w; wdata = d; start = 1'b1;
        lat_seen = -1; n_done = 0; addr_seen = '0;
        for (int i = 1; i <= 40 && lat_seen < 0; i++) begin
            @(negedge clk);
            if (i == 1) addr_seen = ram_addr;
            if (done) begin
                lat_seen = i;
                n_done++;
            end
        end
        if (lat_seen < 0) chk("done_timeout", 0, 1);
        for (int i = 0; i < hold; i++) begin
            // inputs wander while start is held; they must be ignored
            matrix_sel = 2'($urandom); row = 3'($urandom); col = 3'($urandom);
            wr = 1'($urandom); wdata = DW'($urandom);
            @(negedge clk);
            if (done) n_done++;
        end
        start = 1'b0;
    endtask

    initial begin
        int            lat, nd;
        logic [AW-1:0] a;
        for (int i = 0; i < 128; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        reset = 1'b1; start = 1'b0; wr = 1'b0; matrix_sel = '0;
        row = '0; col = '0; wdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_rdata", rdata, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);

        // write (0,1,2) = 7F
        do_req(2'd0, 3'd1, 3'd2, 1'b1, 8'h7F, 0, lat, a, nd);
        chk("wr_addr_lit", a, 7);
        chk("wr_lat_lit", lat, 2);
        chk("wr_err_lit", error, 0);

        // read it back
        do_req(2'd0, 3'd1, 3'd2, 1'b0, 8'h00, 0, lat, a, nd);
        chk("rd_lat_lit", lat, 4);
        chk("rd_data_lit", rdata, 8'h7F);

        // corner element of last matrix
        do_req(2'd2, 3'd4, 3'd4, 1'b1, 8'h80, 0, lat, a, nd);
        chk("wr74_addr_lit", a, 74);
        do_req(2'd2, 3'd4, 3'd4, 1'b0, 8'h00, 0, lat, a, nd);
        chk("rd74_data_lit", $signed(rdata), -128);

        // invalid read must not disturb rdata
        do_req(2'd0, 3'd1, 3'd2, 1'b0, 8'h00, 0, lat, a, nd);
        do_req(2'd0, 3'd5, 3'd0, 1'b0, 8'h00, 0, lat, a, nd);
        chk("inv_lat_lit", lat, 2);
        chk("inv_err_lit", error, 1);
        chk("inv_rdata_lit", rdata, 8'h7F);
        do_req(2'd3, 3'd0, 3'd0, 1'b1, 8'h55, 0, lat, a, nd);
        chk("inv_sel_err_lit", error, 1);

        // start held long after done: exactly one completion
        do_req(2'd1, 3'd0, 3'd3, 1'b1, 8'h3C, 10, lat, a, nd);
        chk("hold_one_done", nd, 1);
        do_req(2'd1, 3'd0, 3'd3, 1'b0, 8'h00, 0, lat, a, nd);
        chk("after_hold_lat", lat, 4);
        chk("after_hold_rdata", rdata, 8'h3C);

        // reset while waiting on read data
        while (busy) @(negedge clk);
        matrix_sel = 2'd0; row = 3'd1; col = 3'd2; wr = 1'b0; start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_rdata", rdata, 0);
        nd = 0;
        repeat (6) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("midrst_no_done", nd, 0);
        do_req(2'd0, 3'd1, 3'd2, 1'b0, 8'h00, 0, lat, a, nd);
        chk("post_rst_lat", lat, 4);
        chk("post_rst_rdata", rdata, 8'h7F);

        // random traffic, addresses kept in a small window to get hits
        for (int t = 0; t < 200; t++) begin
            do_req(2'($urandom_range(0, 3)), 3'($urandom_range(0, 5)),
                   3'($urandom_range(0, 5)), 1'($urandom), DW'($urandom),
                   $urandom_range(0, 3), lat, a, nd);
            chk("rand_one_done", nd, 1);
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/matrix_mem_access.md
# matrix_mem_access

Executes the coprocessor's READ and WRITE instructions against the shared matrix RAM. It sits directly downstream of the instruction controller's EXECUTE state and receives its `start`/`wr` handshake plus the decoded address and data fields. It converts a (matrix, row, col) element address into a linear RAM address, performs the access, handles the RAM's read latency, and returns `done` with read data or an error flag. The RAM itself is external so that the arithmetic units can share it through the same port arbitration.

## Interface
- `DATA_W`, 8: element width, signed two's complement.
- `N`, 5: matrix dimension; 5x5 is the largest supported (DET5).
- `NUM_MAT`, 3: matrices resident in RAM (A, B, result).
- `ADDR_W`, $clog2(NUM_MAT*N*N) = 7: RAM address width.
- `READ_LAT`, 2: RAM read latency in clock edges (M10K with output register); must be 1 or more.
- `clk`  in  1  clock. One clock; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; held high by the controller until it samples `done`.
- `wr`  in  1  1 = WRITE, 0 = READ; valid while `start` is high.
- `matrix_sel`  in  2  matrix index.
- `row`  in  3  element row.
- `col`  in  3  element column.
- `wdata`  in  DATA_W  write data.
- `rdata`  out  DATA_W  last successfully read element.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  the last request had an out-of-range address.
- `busy`  out  1  high in every state except IDLE.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  DATA_W  RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data.

## Operation
- All outputs are registered. Reset values: state = IDLE, `rdata` = 0, `done` = 0, `error` = 0, `busy` = 0, `ram_addr` = 0, `ram_we` = 0, `ram_wdata` = 0.
- **IDLE**
  - On `start` = 1: latch `wr`, `matrix_sel`, `row`, `col` and `wdata`; clear `error`; go to ISSUE.
  - Inputs are not sampled again until the next IDLE acceptance.
- **ISSUE**
  - The request is invalid if `row` >= N, `col` >= N or `matrix_sel` >= NUM_MAT. For an invalid request: set `error`, keep `ram_we` = 0, go to DONE.
  - Otherwise drive `ram_addr` = `matrix_sel`*N*N + `row`*N + `col`, computed at ADDR_W width with no truncation for legal inputs.
  - Valid write: `ram_we` = 1 and `ram_wdata` = `wdata` for exactly this cycle; go to DONE.
  - Valid read: load the latency counter with READ_LAT-1; go to WAIT.
- **WAIT**
  - Decrement the counter on each edge.
  - On the edge where the counter is 0: `rdata` <= `ram_rdata`; go to DONE.
- **DONE**
  - `done` = 1 for this single cycle; go to RELEASE.
- **RELEASE**
  - Go to IDLE on the first edge where `start` = 0.
  - A `start` held high past `done` never retriggers an access.
- `rdata` changes only on a successful read. Invalid reads and all writes leave it unchanged.
- `error` holds its value until the next accepted `start`.

## Timing
- Edge S0 accepts `start` (IDLE to ISSUE).
- Write: `done` is high in the cycle after S0+1 (2-edge latency). `ram_we` is high for exactly the one cycle between S0 and S0+1.
- Read: the RAM samples the address at S0+1. `rdata` and `done` rise together after S0+1+READ_LAT (4 edges when READ_LAT = 2).
- Invalid request: `done` after 2 edges, `error` = 1 in the same cycle as `done`, no RAM write.
- Minimum spacing between requests: when `start` drops at the edge that samples `done`, a new request is accepted 2 edges after `done`.
- Reset mid-operation: return to IDLE with all outputs at their reset values and no `done` issued. A write whose `ram_we` cycle coincides with the reset edge is still committed by the RAM; this is accepted behaviour.

## Structure
- Package `coproc_pkg`:
  - opcode constants (READ = 4'b0001, WRITE = 4'b0010, through DET5 = 4'b1100);
  - DATA_W, N and NUM_MAT;
  - the state encoding for IDLE, ISSUE, WAIT, DONE and RELEASE.
- Sub-module `matrix_addr_gen`: combinational. Produces the linear address and the range-valid flag from `matrix_sel`/`row`/`col`. It is reused by the arithmetic units.

## Test plan
- Write sel=0, row=1, col=2, wdata=8'h7F -> `ram_addr` = 7, `ram_we` high exactly 1 cycle, `done` 2 edges after S0, `error` = 0.
- Read sel=0, row=1, col=2 against a RAM model with READ_LAT=2 holding 8'h7F -> `rdata` = 8'h7F and `done` both 4 edges after S0; `ram_we` never asserted.
- Write sel=2, row=4, col=4, wdata=8'h80 -> `ram_addr` = 74; read back gives `rdata` = 8'h80 (-128).
- Read row=5, col=0 with prior `rdata` = 8'h7F -> `error` = 1, `done` at 2 edges, `rdata` stays 8'h7F, no RAM write.
- Hold `start` high for 10 cycles after `done` -> exactly one `done` pulse. Drop `start` for 1 cycle and raise it again -> the second request completes normally.
- Assert `reset` during WAIT of a read -> no `done`, `rdata` = 0, `busy` = 0 next cycle, and the next request completes normally.
